// File: rtl/cpu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : cpu_regfile_mp
// Brief  : Multi-port register file: N combinational reads, byte/pair/flag
//          writes committed on the end-of-M-cycle strobe, sticky error flag.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_regfile_mp #(
  parameter  int DATA_W    = 8,
  parameter  int NUM_REGS  = 12,
  parameter  int NUM_RD    = 3,
  parameter  int FLAG_REG  = 6,
  parameter  int FLAG_BITS = 4,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       commit_i,
  input  logic [NUM_RD*IDX_W-1:0]    rd_idx_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic [1:0]                 pair_op_i,
  input  logic [IDX_W-1:0]           pair_idx_i,
  input  logic [2*DATA_W-1:0]        pair_data_i,
  output logic [2*DATA_W-1:0]        pair_out_o,
  input  logic                       flag_we_i,
  input  logic [FLAG_BITS-1:0]       flag_data_i,
  output logic [FLAG_BITS-1:0]       flags_o,
  input  logic                       err_clr_i,
  output logic                       err_o
);

  localparam logic [1:0] c_OP_NONE = 2'd0;
  localparam logic [1:0] c_OP_LOAD = 2'd1;
  localparam logic [1:0] c_OP_INC  = 2'd2;
  localparam logic [1:0] c_OP_DEC  = 2'd3;

  // Keeps only the flag bits of FLAG_REG; the low bits are never stored.
  localparam logic [DATA_W-1:0] c_FLAG_MASK = {{FLAG_BITS{1'b1}}, {(DATA_W-FLAG_BITS){1'b0}}};
  localparam logic [2*DATA_W-1:0] c_ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   reg_q [NUM_REGS];
  logic [DATA_W-1:0]   reg_d [NUM_REGS];
  logic                err_q;
  logic                err_d;

  logic [IDX_W:0]      w_pair_lo_idx;
  logic                w_pair_legal;
  logic                w_pair_act;
  logic                w_pair_err;
  logic                w_overlap;
  logic [DATA_W-1:0]   w_pair_hi;
  logic [DATA_W-1:0]   w_pair_lo;
  logic [2*DATA_W-1:0] w_pair_cur;
  logic [2*DATA_W-1:0] w_pair_new;

  // ---------------------------------------------------------------------------
  // Pair decode and current pair value (also drives pair_out)
  // ---------------------------------------------------------------------------
  assign w_pair_lo_idx = {1'b0, pair_idx_i} + {{IDX_W{1'b0}}, 1'b1};
  assign w_pair_legal  = (pair_idx_i[0] == 1'b0) && (int'(pair_idx_i) < NUM_REGS - 1);
  assign w_pair_act    = (pair_op_i != c_OP_NONE) && w_pair_legal;
  assign w_pair_err    = (pair_op_i != c_OP_NONE) && !w_pair_legal;
  assign w_overlap     = w_pair_act && wr_en_i &&
                         ((wr_idx_i == pair_idx_i) || ({1'b0, wr_idx_i} == w_pair_lo_idx));

  always_comb begin
    w_pair_hi = '0;
    w_pair_lo = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (pair_idx_i == IDX_W'(i)) begin
        w_pair_hi = reg_q[i];
      end
      if (w_pair_lo_idx == (IDX_W+1)'(i)) begin
        w_pair_lo = reg_q[i];
      end
    end
  end

  assign w_pair_cur = {w_pair_hi, w_pair_lo};
  assign pair_out_o = w_pair_cur;

  // Inc/dec wrap naturally at the full pair width, carrying between halves.
  always_comb begin
    w_pair_new = w_pair_cur;
    case (pair_op_i)
      c_OP_LOAD: w_pair_new = pair_data_i;
      c_OP_INC:  w_pair_new = w_pair_cur + c_ONE;
      c_OP_DEC:  w_pair_new = w_pair_cur - c_ONE;
      default:   w_pair_new = w_pair_cur;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state: byte write, then pair (wins on overlap), then flag merge
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_d = reg_q;
    err_d = err_q;
    if (commit_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_i && !w_overlap && (wr_idx_i == IDX_W'(i))) begin
          reg_d[i] = wr_data_i;
        end
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_pair_act && (pair_idx_i == IDX_W'(i))) begin
          reg_d[i] = w_pair_new[2*DATA_W-1 -: DATA_W];
        end
        if (w_pair_act && (w_pair_lo_idx == (IDX_W+1)'(i))) begin
          reg_d[i] = w_pair_new[DATA_W-1:0];
        end
      end
      reg_d[FLAG_REG] = reg_d[FLAG_REG] & c_FLAG_MASK;
      if (flag_we_i) begin
        reg_d[FLAG_REG][DATA_W-1 -: FLAG_BITS] = flag_data_i;
      end
      if (err_clr_i) begin
        err_d = 1'b0;
      end
      if (w_pair_err || w_overlap) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= reg_d[i];
      end
      err_q <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: out-of-range indices return 0
  // ---------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [IDX_W-1:0]  w_idx;
      logic [DATA_W-1:0] w_data;

      assign w_idx = rd_idx_i[k*IDX_W +: IDX_W];

      always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_idx == IDX_W'(i)) begin
            w_data = reg_q[i];
          end
        end
      end

      assign rd_data_o[k*DATA_W +: DATA_W] = w_data;
    end
  endgenerate

  assign flags_o = reg_q[FLAG_REG][DATA_W-1 -: FLAG_BITS];
  assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_regfile_mp
// Brief  : Self-checking bench for cpu_regfile_mp against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_regfile_mp;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        commit_i;
  logic [11:0] rd_idx_i;
  logic [23:0] rd_data_o;
  logic        wr_en_i;
  logic [3:0]  wr_idx_i;
  logic [7:0]  wr_data_i;
  logic [1:0]  pair_op_i;
  logic [3:0]  pair_idx_i;
  logic [15:0] pair_data_i;
  logic [15:0] pair_out_o;
  logic        flag_we_i;
  logic [3:0]  flag_data_i;
  logic [3:0]  flags_o;
  logic        err_clr_i;
  logic        err_o;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  always #5 clk_i = ~clk_i;

  cpu_regfile_mp dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .commit_i    (commit_i),
    .rd_idx_i    (rd_idx_i),
    .rd_data_o   (rd_data_o),
    .wr_en_i     (wr_en_i),
    .wr_idx_i    (wr_idx_i),
    .wr_data_i   (wr_data_i),
    .pair_op_i   (pair_op_i),
    .pair_idx_i  (pair_idx_i),
    .pair_data_i (pair_data_i),
    .pair_out_o  (pair_out_o),
    .flag_we_i   (flag_we_i),
    .flag_data_i (flag_data_i),
    .flags_o     (flags_o),
    .err_clr_i   (err_clr_i),
    .err_o       (err_o)
  );

  // Behavioural model: plain integer registers, pair treated as a 16-bit number.
  int m [12];
  bit me;

  always @(posedge clk_i or posedge reset_i) begin : model
    int p, v, wi;
    bit legal, ov;
    if (reset_i) begin
      foreach (m[i]) m[i] = 0;
      me = 0;
    end else if (commit_i) begin
      p     = int'(pair_idx_i);
      wi    = int'(wr_idx_i);
      legal = (pair_op_i != 0) && (p % 2 == 0) && (p < 11);
      v     = legal ? (m[p] * 256 + m[p+1]) : 0;
      case (pair_op_i)
        2'd1:    v = int'(pair_data_i);
        2'd2:    v = (v + 1) % 65536;
        2'd3:    v = (v + 65535) % 65536;
        default: v = v;
      endcase
      ov = legal && wr_en_i && (wi == p || wi == p + 1);
      if (wr_en_i && wi < 12 && !ov) m[wi] = int'(wr_data_i);
      if (legal) begin
        m[p]   = v / 256;
        m[p+1] = v % 256;
      end
      m[6] = (m[6] / 16) * 16;
      if (flag_we_i) m[6] = int'(flag_data_i) * 16;
      if (ov || (pair_op_i != 0 && !legal)) me = 1;
      else if (err_clr_i) me = 0;
    end
  end

  function automatic int exp_rd(int idx);
    return (idx < 12) ? m[idx] : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("model_rd", 32'(rd_data_o[k*8 +: 8]), 32'(exp_rd(int'(rd_idx_i[k*4 +: 4]))));
      end
      chk("model_pair", 32'(pair_out_o),
          32'(exp_rd(int'(pair_idx_i)) * 256 + exp_rd(int'(pair_idx_i) + 1)));
      chk("model_flags", 32'(flags_o), 32'(m[6] / 16));
      chk("model_err", 32'(err_o), 32'(me));
    end
  end

  task automatic clear_wr();
    commit_i  = 1'b0;
    wr_en_i   = 1'b0;
    pair_op_i = 2'd0;
    flag_we_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  // Called at posedge+2; commit is sampled on the next edge.
  task automatic do_commit();
    commit_i = 1'b1;
    @(posedge clk_i);
    #1 clear_wr();
    #1;
  endtask

  initial begin
    reset_i     = 1'b1;
    rd_idx_i    = {4'd0, 4'd6, 4'd11};
    wr_idx_i    = '0;
    wr_data_i   = '0;
    pair_idx_i  = 4'd4;
    pair_data_i = '0;
    flag_data_i = '0;
    clear_wr();
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    cmp_en = 1;
    #1;
    chk("reset_rd", 32'(rd_data_o), 32'h0);
    chk("reset_pair", 32'(pair_out_o), 32'h0);
    chk("reset_flags", 32'(flags_o), 32'h0);
    chk("reset_err", 32'(err_o), 32'h0);

    // Random inputs without commit must not disturb state.
    for (int c = 0; c < 16; c++) begin
      @(posedge clk_i);
      #1;
      rd_idx_i    = 12'($urandom);
      wr_en_i     = 1'($urandom);
      wr_idx_i    = 4'($urandom);
      wr_data_i   = 8'($urandom);
      pair_op_i   = 2'($urandom);
      pair_idx_i  = 4'($urandom);
      pair_data_i = 16'($urandom);
      flag_we_i   = 1'($urandom);
      flag_data_i = 4'($urandom);
      err_clr_i   = 1'($urandom);
    end
    clear_wr();
    #1;
    chk("hold_rd", 32'(rd_data_o), 32'h0);
    chk("hold_err", 32'(err_o), 32'h0);

    // Byte write, then repeat without commit.
    rd_idx_i  = {4'd0, 4'd7, 4'd7};
    wr_en_i   = 1'b1;
    wr_idx_i  = 4'd7;
    wr_data_i = 8'h3C;
    do_commit();
    chk("byte_wr", 32'(rd_data_o), 32'h003C3C);
    wr_en_i   = 1'b1;
    wr_data_i = 8'h55;
    @(posedge clk_i);
    #1 wr_en_i = 1'b0;
    #1;
    chk("byte_nocommit", 32'(rd_data_o), 32'h003C3C);

    // Pair load/inc/dec with wrap and carry.
    pair_idx_i  = 4'd4;
    pair_op_i   = 2'd1;
    pair_data_i = 16'hFFFF;
    do_commit();
    chk("hl_load", 32'(pair_out_o), 32'hFFFF);
    pair_op_i = 2'd2;
    do_commit();
    chk("hl_inc_wrap", 32'(pair_out_o), 32'h0000);
    rd_idx_i = {4'd5, 4'd4, 4'd5};
    #1 chk("hl_halves", 32'(rd_data_o), 32'h000000);
    pair_op_i = 2'd3;
    do_commit();
    chk("hl_dec_wrap", 32'(pair_out_o), 32'hFFFF);
    pair_idx_i  = 4'd0;
    pair_op_i   = 2'd1;
    pair_data_i = 16'h00FF;
    do_commit();
    pair_op_i = 2'd2;
    do_commit();
    chk("bc_inc_carry", 32'(pair_out_o), 32'h0100);

    // Byte write to flags register merged with flag port.
    wr_en_i     = 1'b1;
    wr_idx_i    = 4'd6;
    wr_data_i   = 8'hAF;
    flag_we_i   = 1'b1;
    flag_data_i = 4'b0101;
    do_commit();
    rd_idx_i = {4'd6, 4'd6, 4'd6};
    #1;
    chk("flag_merge_rd", 32'(rd_data_o), 32'h505050);
    chk("flag_merge_flags", 32'(flags_o), 32'h5);
    chk("flag_merge_err", 32'(err_o), 32'h0);

    // Overlap, err_clr, illegal pair index.
    wr_en_i     = 1'b1;
    wr_idx_i    = 4'd5;
    wr_data_i   = 8'h12;
    pair_idx_i  = 4'd4;
    pair_op_i   = 2'd1;
    pair_data_i = 16'hBEEF;
    do_commit();
    chk("overlap_pair", 32'(pair_out_o), 32'hBEEF);
    chk("overlap_err", 32'(err_o), 32'h1);
    err_clr_i = 1'b1;
    do_commit();
    chk("err_clr", 32'(err_o), 32'h0);
    pair_idx_i  = 4'd3;
    pair_op_i   = 2'd1;
    pair_data_i = 16'h1234;
    do_commit();
    chk("illegal_err", 32'(err_o), 32'h1);
    pair_idx_i = 4'd4;
    #1 chk("illegal_nochange", 32'(pair_out_o), 32'hBEEF);

    // Reset mid-cycle with writes pending.
    @(posedge clk_i);
    #1;
    rd_idx_i    = {4'd0, 4'd2, 4'd6};
    wr_en_i     = 1'b1;
    wr_idx_i    = 4'd2;
    wr_data_i   = 8'h99;
    pair_idx_i  = 4'd0;
    pair_op_i   = 2'd1;
    pair_data_i = 16'hABCD;
    commit_i    = 1'b1;
    #2 reset_i = 1'b1;
    #1;
    chk("midreset_rd", 32'(rd_data_o), 32'h0);
    chk("midreset_pair", 32'(pair_out_o), 32'h0);
    chk("midreset_err", 32'(err_o), 32'h0);
    clear_wr();
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    #1;
    wr_en_i   = 1'b1;
    wr_idx_i  = 4'd2;
    wr_data_i = 8'h77;
    do_commit();
    chk("post_reset_wr", 32'(rd_data_o), 32'h007700);
    chk("post_reset_pair", 32'(pair_out_o), 32'h0);

    // Randomised traffic checked by the compare process.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk_i);
      #1;
      commit_i    = ($urandom_range(0, 2) == 0);
      rd_idx_i    = 12'($urandom);
      wr_en_i     = 1'($urandom);
      wr_idx_i    = 4'($urandom_range(0, 15));
      wr_data_i   = 8'($urandom);
      pair_op_i   = 2'($urandom);
      pair_idx_i  = ($urandom_range(0, 3) != 0) ? 4'(2 * $urandom_range(0, 5))
                                                : 4'($urandom_range(0, 15));
      pair_data_i = 16'($urandom);
      flag_we_i   = 1'($urandom);
      flag_data_i = 4'($urandom);
      err_clr_i   = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk_i);
    #1 clear_wr();
    @(posedge clk_i);
    @(negedge clk_i);
    cmp_en = 0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
